adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_if.sv | 41 ++++
 rtl/adder_arb.sv | 106 ++++++++++
 tb/tb_adder_arb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adder_arb_if.sv
// Handshake bundle between two operand requesters, the shared adder and the result consumer.
// The master side is the requester/consumer environment; the slave side is adder_arb.
interface adder_arb_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_cout;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_z, rsp_cout, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_z, rsp_cout, rsp_id
    );
endinterface

// File: rtl/adder_arb.sv
// Two-requester round-robin arbiter in front of one shared ripple-carry add/sub unit.
//   state | meaning
//   IDLE  | arbitrate, accept one operand set from the granted requester
//   EXEC  | ripple adder result registered into the response holding regs
//   RESP  | result offered to the consumer until rsp_ready
module adder_arb #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_arb_if.slave  bus,
    output logic        busy,
    output logic [15:0] op_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_sub_q, op_id_q;
    logic [WIDTH-1:0] rsp_z_q;
    logic             rsp_cout_q, rsp_id_q;
    logic [15:0]      op_cnt_q;

    logic             gnt_valid, gnt_id, accept;
    logic             ready0, ready1;
    logic [WIDTH-1:0] b_eff, sum;
    logic [WIDTH:0]   carry;

    // On a tie the grant goes to whoever was not served last.
    always_comb begin
        gnt_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) gnt_id = ~rr_q;
        else                                  gnt_id = bus.req1_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst_n gates the readies so nothing is accepted while reset is held.
    always_comb begin
        busy   = (state_q != IDLE);
        ready0 = (state_q == IDLE) && rst_n && gnt_valid && !gnt_id;
        ready1 = (state_q == IDLE) && rst_n && gnt_valid &&  gnt_id;
        accept = ready0 | ready1;
    end

    always_comb begin
        b_eff    = op_sub_q ? ~op_b_q : op_b_q;
        sum      = '0;
        carry    = '0;
        carry[0] = op_sub_q;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = op_a_q[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (op_a_q[i] & b_eff[i]) | (carry[i] & (op_a_q[i] ^ b_eff[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sub_q   <= 1'b0;
            op_id_q    <= 1'b0;
            rsp_z_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && accept) begin
                op_a_q   <= gnt_id ? bus.req1_a   : bus.req0_a;
                op_b_q   <= gnt_id ? bus.req1_b   : bus.req0_b;
                op_sub_q <= gnt_id ? bus.req1_sub : bus.req0_sub;
                op_id_q  <= gnt_id;
            end
            if (state_q == EXEC) begin
                rsp_z_q    <= sum;
                rsp_cout_q <= carry[WIDTH];
                rsp_id_q   <= op_id_q;
                rr_q       <= op_id_q;
            end
            if (state_q == RESP && bus.rsp_ready) op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_id     = rsp_id_q;
    assign op_cnt         = op_cnt_q;
endmodule

// File: tb/tb_adder_arb.sv
// Directed bench for adder_arb: table of single-requester operations plus
// contention, backpressure, reset-in-flight and counter-wrap sequences.
module tb_adder_arb;
    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_cnt;

    adder_arb_if #(.WIDTH(32)) bus ();

    adder_arb #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] z;
        logic        cout;
    } vec_t;

    vec_t vecs[7];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [15:0] exp_cnt);
        @(negedge clk);
        if (v.id) begin
            bus.req1_valid = 1'b1; bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_sub = v.sub;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_sub = v.sub;
        end
        #1;
        check("vec_ready", {bus.req1_ready, bus.req0_ready}, v.id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("vec_exec", {busy, bus.rsp_valid, bus.req1_ready, bus.req0_ready}, 4'b1000);
        @(posedge clk); #1;
        check("vec_rsp_valid", bus.rsp_valid, 1'b1);
        check("vec_result", {bus.rsp_id, bus.rsp_cout, bus.rsp_z}, {v.id, v.cout, v.z});
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("vec_done", {bus.rsp_valid, busy, op_cnt}, {2'b00, exp_cnt});
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_000A, 32'h0000_000A, 1'b1, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h0FED_CBA8, 1'b0, 32'h2222_2220, 1'b0};

        rst_n          = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.rsp_ready  = 1'b0;
        #1;
        check("reset_state",
              {bus.rsp_valid, busy, bus.rsp_cout, bus.rsp_id, bus.req1_ready, bus.req0_ready, bus.rsp_z, op_cnt},
              {6'b000000, 32'h0, 16'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], 16'(k + 1));

        // Contention: both requesters valid throughout, consumer always ready.
        bus.req0_a = 32'd100; bus.req0_b = 32'd1; bus.req0_sub = 1'b0;
        bus.req1_a = 32'd200; bus.req1_b = 32'd2; bus.req1_sub = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        rst_n = 1'b0;
        #1;
        check("no_ready_in_reset", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            check("rr_exec_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            @(posedge clk); #1;
            check("rr_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_z},
                  {1'b1, 1'(k % 2), (k % 2) ? 32'd198 : 32'd101});
            @(posedge clk);
            @(negedge clk);
        end
        check("rr_op_cnt", op_cnt, 16'd4);

        // Backpressure, then reset during an in-flight EXEC.
        bus.req0_a = 32'd7; bus.req0_b = 32'd9; bus.req0_sub = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_first", {bus.rsp_valid, bus.rsp_z}, {1'b1, 32'd16});
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_hold", {bus.rsp_valid, bus.req1_ready, bus.req0_ready, bus.rsp_z, op_cnt},
                  {3'b100, 32'd16, 16'd0});
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp_release", {bus.rsp_valid, op_cnt}, {1'b0, 16'd1});
        check("bp_next_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
        @(posedge clk); #1;
        check("mid_in_exec", {busy, bus.rsp_valid}, 2'b10);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {bus.rsp_valid, busy, bus.rsp_cout, bus.rsp_id, bus.req1_ready, bus.req0_ready, bus.rsp_z, op_cnt},
              {6'b000000, 32'h0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_tie_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_next_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_z}, {2'b10, 32'd16});
        @(posedge clk); #1;
        check("mid_op_cnt", op_cnt, 16'd1);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Counter wrap: preload the count just below the wrap point.
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        #1;
        check("wrap_preload", op_cnt, 16'hFFFF);
        run_vec(vecs[0], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected end of test");
        $fatal(1, "timeout");
    end
endmodule
